// File: rtl/bram_capture_writer_pkg.sv
// rtl/bram_capture_writer_pkg.sv - state encoding and length clamp for the BRAM capture writer
// Contents:
//   state_t   : 3-bit FSM encoding IDLE, SETTLE, CAPTURE, RELEASE, DONE
//   clamp_len : maps a requested word count onto 1..depth (0 or oversize means full depth)
package bram_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int unsigned clamp_len(input int unsigned cfg_len,
                                              input int unsigned depth);
        if (cfg_len == 0 || cfg_len > depth) begin
            return depth;
        end
        return cfg_len;
    endfunction

endpackage

// File: rtl/bram_capture_writer_if.sv
// rtl/bram_capture_writer_if.sv - sample stream interface feeding the BRAM capture writer
// Signals:
//   tdata  : sample word
//   tvalid : sample valid, driven by the source
//   tready : sink accepts the sample this cycle
// Modports: master = sample source, slave = capture writer
interface bram_capture_writer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/bram_capture_writer.sv
// rtl/bram_capture_writer.sv - streams a bounded capture into BRAM port A, then hands the BRAM back
// Ports:
//   aclk, aresetn         : clock and synchronous active-low reset
//   cfg_len               : words per capture (0 or > depth means full depth), latched at start
//   start, abort          : arm pulse (IDLE/DONE only) and level abort (wins over start)
//   s_axis                : sample stream, slave side; tready high only in CAPTURE
//   bram_sel              : switch select, 1 while the writer owns the BRAM
//   busy, done, sts_count : status; sts_count holds the words written by the current/last capture
//   bram_porta_*          : registered BRAM port A write signals, clock forwarded from aclk
module bram_capture_writer
    import bram_capture_pkg::*;
#(
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [BRAM_ADDR_WIDTH:0]   cfg_len,
    input  logic                       start,
    input  logic                       abort,
    bram_capture_writer_if.slave       s_axis,
    output logic                       bram_sel,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_ADDR_WIDTH:0]   sts_count,
    output logic                       bram_porta_clk,
    output logic                       bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_porta_wrdata,
    output logic                       bram_porta_we
);

    localparam int          AW    = BRAM_ADDR_WIDTH;
    localparam int          LW    = BRAM_ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << BRAM_ADDR_WIDTH;

    state_t                       state_q;
    state_t                       state_d;
    logic   [3:0]                 settle_cnt_q;
    logic   [LW-1:0]              len_q;
    logic   [LW-1:0]              count_q;
    logic   [LW-1:0]              count_inc;
    logic   [AW-1:0]              addr_q;
    logic   [BRAM_DATA_WIDTH-1:0] wrdata_q;
    logic                         we_q;
    logic                         tready_c;
    logic                         beat;
    logic                         settle_last;

    // Abort suppresses the beat in its own cycle so nothing is written on the abort edge.
    assign beat        = tready_c && s_axis.tvalid && !abort;
    assign count_inc   = count_q + LW'(1);
    assign settle_last = (settle_cnt_q == 4'(SETTLE_CYCLES - 1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
                ST_SETTLE:        if (settle_last) state_d = ST_CAPTURE;
                // The final beat leaves CAPTURE at once, so tready drops before any extra beat.
                ST_CAPTURE:       if (beat && count_inc == len_q) state_d = ST_RELEASE;
                // One cycle for the last registered write to land before the switch flips back.
                ST_RELEASE:       state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bram_sel = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        tready_c = 1'b0;
        case (state_q)
            ST_SETTLE:  begin bram_sel = 1'b1; busy = 1'b1; end
            ST_CAPTURE: begin bram_sel = 1'b1; busy = 1'b1; tready_c = 1'b1; end
            ST_RELEASE: begin bram_sel = 1'b1; busy = 1'b1; end
            ST_DONE:    done = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            settle_cnt_q <= '0;
            len_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            wrdata_q     <= '0;
            we_q         <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (!abort) begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            settle_cnt_q <= '0;
                            count_q      <= '0;
                            len_q        <= LW'(clamp_len(32'(cfg_len), DEPTH));
                        end
                    end
                    ST_SETTLE: settle_cnt_q <= settle_cnt_q + 4'd1;
                    ST_CAPTURE: begin
                        if (beat) begin
                            we_q     <= 1'b1;
                            addr_q   <= count_q[AW-1:0];
                            wrdata_q <= s_axis.tdata;
                            count_q  <= count_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_axis.tready     = tready_c;
    assign sts_count         = count_q;
    assign bram_porta_clk    = aclk;
    assign bram_porta_rst    = ~aresetn;
    assign bram_porta_addr   = addr_q;
    assign bram_porta_wrdata = wrdata_q;
    assign bram_porta_we     = we_q;

endmodule
